// File: rtl/rtc_bus_reader.sv
// rtl/rtc_bus_reader.sv - RTC multiplexed-bus reader with BCD conversion and blanking-window streamer
module rtc_bus_reader #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int LEAD    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       window,
  input  logic [7:0] bus_ad_in,
  output logic [7:0] bus_ad_out,
  output logic       bus_ad_oe,
  output logic       bus_cs_n,
  output logic       bus_rd_n,
  output logic       bus_wr_n,
  output logic       bus_a_d,
  output logic [7:0] dato,
  output logic       inicio_secuencia,
  output logic       busy,
  output logic       frame_done
);

  localparam int NREG = 8;

  // Counter reload values: each timed state runs for (load + 1) cycles.
  localparam logic [7:0] LD_SETUP  = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_PULSE  = 8'(T_PULSE - 1);
  localparam logic [7:0] LD_HOLD   = 8'(T_HOLD - 1);
  localparam logic [7:0] LD_STREAM = 8'(LEAD + NREG - 1);
  localparam logic [7:0] LEAD8     = 8'(LEAD);

  typedef enum logic [3:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    R_STROBE,
    R_HOLD,
    WAIT_WIN,
    STREAM,
    DONE
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] rbuf [NREG];

  // Next values of the registered outputs, derived from the next state.
  logic [7:0] ad_out_d;
  logic       ad_oe_d;
  logic       cs_n_d;
  logic       rd_n_d;
  logic       wr_n_d;
  logic       a_d_d;
  logic [7:0] dato_d;
  logic       inicio_d;
  logic       busy_d;
  logic       frame_done_d;

  logic [7:0] pos_n;
  logic [2:0] sel_n;

  // Fixed RTC register map: seconds through week number.
  function automatic logic [7:0] reg_addr(input logic [2:0] i);
    logic [7:0] a;
    case (i)
      3'd0:    a = 8'h21;
      3'd1:    a = 8'h22;
      3'd2:    a = 8'h23;
      3'd3:    a = 8'h24;
      3'd4:    a = 8'h25;
      3'd5:    a = 8'h26;
      3'd6:    a = 8'h27;
      default: a = 8'h28;
    endcase
    return a;
  endfunction

  // Two-digit BCD to binary; any non-decimal nibble marks the byte invalid (0xFF).
  function automatic logic [7:0] bcd_to_bin(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (hi > 4'd9 || lo > 4'd9) begin
      return 8'hFF;
    end
    // hi*10 = hi*8 + hi*2
    return {1'b0, hi, 3'b000} + {3'b000, hi, 1'b0} + {4'b0000, lo};
  endfunction

  // State, phase counter and register index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      idx   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  // Next-state logic: timed phases advance when the down-counter reaches zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = A_SETUP;
          cnt_n   = LD_SETUP;
          idx_n   = 3'd0;
        end
      end
      A_SETUP: begin
        if (cnt == 8'd0) begin
          state_n = A_STROBE;
          cnt_n   = LD_PULSE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      A_STROBE: begin
        if (cnt == 8'd0) begin
          state_n = A_HOLD;
          cnt_n   = LD_HOLD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      A_HOLD: begin
        if (cnt == 8'd0) begin
          state_n = R_STROBE;
          cnt_n   = LD_PULSE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      R_STROBE: begin
        if (cnt == 8'd0) begin
          state_n = R_HOLD;
          cnt_n   = LD_HOLD;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      R_HOLD: begin
        if (cnt == 8'd0) begin
          if (idx == 3'd7) begin
            state_n = WAIT_WIN;
            cnt_n   = 8'd0;
          end else begin
            state_n = A_SETUP;
            cnt_n   = LD_SETUP;
            idx_n   = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      WAIT_WIN: begin
        if (window) begin
          state_n = STREAM;
          cnt_n   = LD_STREAM;
        end
      end
      STREAM: begin
        // The stream runs to completion regardless of window.
        if (cnt == 8'd0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
        idx_n   = 3'd0;
      end
    endcase
  end

  // Stream position of the upcoming cycle: 0..LEAD-1 are lead-in zeros, then buffer bytes.
  always_comb begin
    pos_n = LD_STREAM - cnt_n;
    sel_n = 3'(pos_n - LEAD8);
  end

  // Output decode for the upcoming cycle so every output leaves a flop.
  always_comb begin
    ad_out_d     = 8'h00;
    ad_oe_d      = 1'b0;
    cs_n_d       = 1'b1;
    rd_n_d       = 1'b1;
    wr_n_d       = 1'b1;
    a_d_d        = 1'b1;
    dato_d       = 8'h00;
    inicio_d     = 1'b0;
    busy_d       = (state_n != IDLE);
    frame_done_d = 1'b0;
    case (state_n)
      A_SETUP, A_HOLD: begin
        cs_n_d   = 1'b0;
        a_d_d    = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = reg_addr(idx_n);
      end
      A_STROBE: begin
        cs_n_d   = 1'b0;
        a_d_d    = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = reg_addr(idx_n);
        wr_n_d   = 1'b0;
      end
      R_STROBE: begin
        // Driver is released on the same edge rd_n falls, so the bus is never contended.
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      STREAM: begin
        inicio_d = 1'b1;
        if (pos_n >= LEAD8) begin
          dato_d = rbuf[sel_n];
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
      end
      default: begin
        busy_d = (state_n != IDLE);
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_ad_out       <= 8'h00;
      bus_ad_oe        <= 1'b0;
      bus_cs_n         <= 1'b1;
      bus_rd_n         <= 1'b1;
      bus_wr_n         <= 1'b1;
      bus_a_d          <= 1'b1;
      dato             <= 8'h00;
      inicio_secuencia <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      bus_ad_out       <= ad_out_d;
      bus_ad_oe        <= ad_oe_d;
      bus_cs_n         <= cs_n_d;
      bus_rd_n         <= rd_n_d;
      bus_wr_n         <= wr_n_d;
      bus_a_d          <= a_d_d;
      dato             <= dato_d;
      inicio_secuencia <= inicio_d;
      busy             <= busy_d;
      frame_done       <= frame_done_d;
    end
  end

  // Capture and convert the RTC reply on the last cycle of the read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        rbuf[i] <= 8'h00;
      end
    end else if (state == R_STROBE && cnt == 8'd0) begin
      rbuf[idx] <= bcd_to_bin(bus_ad_in);
    end
  end

endmodule
